// File: rtl/alu_share_arb_pkg.sv
// Shared types for the two-port ALU arbiter: opcode encoding, requester ids
// and FSM states.
package alu_share_arb_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'd0;
  localparam alu_op_t OP_SUB  = 4'd1;
  localparam alu_op_t OP_SLL  = 4'd2;
  localparam alu_op_t OP_SLT  = 4'd3;
  localparam alu_op_t OP_SLTU = 4'd4;
  localparam alu_op_t OP_XOR  = 4'd5;
  localparam alu_op_t OP_SRL  = 4'd6;
  localparam alu_op_t OP_SRA  = 4'd7;
  localparam alu_op_t OP_OR   = 4'd8;
  localparam alu_op_t OP_AND  = 4'd9;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// RV32E integer ALU. Purely combinational; undefined opcodes produce 0,
// so their zero flag reads 1.
module alu
  import alu_share_arb_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        zero
);

  logic [4:0] shamt;
  assign shamt = in2[4:0];

  // Opcode decode into the 32-bit result.
  always_comb begin
    // NOTE: assign a default before the case so every path drives out and no latch is inferred.
    out = '0;
    case (op)
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_SLL:  out = in1 << shamt;
      OP_SLT:  out = {31'b0, $signed(in1) < $signed(in2)};
      OP_SLTU: out = {31'b0, in1 < in2};
      OP_XOR:  out = in1 ^ in2;
      OP_SRL:  out = in1 >> shamt;
      OP_SRA:  out = $unsigned($signed(in1) >>> shamt);
      OP_OR:   out = in1 | in2;
      OP_AND:  out = in1 & in2;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between requesters A and B. One transaction in flight: a
// request is accepted in IDLE, its result is registered, and the FSM sits in
// RESP until the owning port takes the response.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int PRIO_MODE = 0  // 0: round-robin, 1: A wins every tie
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  alu_op_t     a_op,
  input  logic [31:0] a_in1,
  input  logic [31:0] a_in2,
  output logic        a_rvalid,
  input  logic        a_rready,
  output logic [31:0] a_result,
  output logic        a_zero,
  input  logic        b_valid,
  output logic        b_ready,
  input  alu_op_t     b_op,
  input  logic [31:0] b_in1,
  input  logic [31:0] b_in2,
  output logic        b_rvalid,
  input  logic        b_rready,
  output logic [31:0] b_result,
  output logic        b_zero,
  output logic        busy
);

  state_t      state;
  state_t      state_next;
  req_id_t     owner;
  req_id_t     last_grant;
  req_id_t     grant;
  logic [31:0] result_q;
  logic        zero_q;
  logic        accept;
  logic        owner_ack;

  alu_op_t     alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out;
  logic        alu_zero;

  // Arbitration: a lone requester wins; ties go by round-robin or to A.
  always_comb begin
    if (a_valid && b_valid) begin
      if (PRIO_MODE != 0) grant = REQ_A;
      else                grant = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (b_valid) begin
      grant = REQ_B;
    end else begin
      grant = REQ_A;
    end
  end

  assign alu_op  = (grant == REQ_B) ? b_op  : a_op;
  assign alu_in1 = (grant == REQ_B) ? b_in1 : a_in1;
  assign alu_in2 = (grant == REQ_B) ? b_in2 : a_in2;

  alu u_alu (
    .op   (alu_op),
    .in1  (alu_in1),
    .in2  (alu_in2),
    .out  (alu_out),
    .zero (alu_zero)
  );

  // Readies are held low during reset and whenever a result is outstanding.
  assign a_ready   = !rst && (state == IDLE) && (grant == REQ_A);
  assign b_ready   = !rst && (state == IDLE) && (grant == REQ_B);
  assign accept    = (a_valid && a_ready) || (b_valid && b_ready);
  assign owner_ack = (owner == REQ_A) ? a_rready : b_rready;

  // State register plus result capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_A;
      last_grant <= REQ_B;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (accept) begin
        result_q   <= alu_out;
        zero_q     <= alu_zero;
        owner      <= grant;
        last_grant <= grant;
      end
    end
  end

  // Next state: IDLE -> RESP on accept, RESP -> IDLE on the owner's rready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RESP;
      RESP:    if (owner_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response outputs: only the owner sees rvalid and data; the other reads 0.
  always_comb begin
    busy     = (state == RESP);
    a_rvalid = busy && (owner == REQ_A);
    b_rvalid = busy && (owner == REQ_B);
    a_result = a_rvalid ? result_q : '0;
    a_zero   = a_rvalid ? zero_q   : 1'b0;
    b_result = b_rvalid ? result_q : '0;
    b_zero   = b_rvalid ? zero_q   : 1'b0;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: a transaction-level model checked
// every cycle, plus directed vectors with literal expected values. A second
// instance in fixed-priority mode shares the stimulus.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 0, b_valid = 0, a_rready = 0, b_rready = 0;
  alu_op_t     a_op = OP_ADD, b_op = OP_ADD;
  logic [31:0] a_in1 = 0, a_in2 = 0, b_in1 = 0, b_in2 = 0;

  logic        a_ready, b_ready, a_rvalid, b_rvalid, a_zero, b_zero, busy;
  logic [31:0] a_result, b_result;
  logic        f_a_ready, f_b_ready, f_a_rvalid, f_b_rvalid, f_a_zero, f_b_zero, f_busy;
  logic [31:0] f_a_result, f_b_result;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
    .a_rvalid(a_rvalid), .a_rready(a_rready), .a_result(a_result), .a_zero(a_zero),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
    .b_rvalid(b_rvalid), .b_rready(b_rready), .b_result(b_result), .b_zero(b_zero),
    .busy(busy)
  );

  alu_share_arb #(.PRIO_MODE(1)) dut_fix (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(f_a_ready), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
    .a_rvalid(f_a_rvalid), .a_rready(a_rready), .a_result(f_a_result), .a_zero(f_a_zero),
    .b_valid(b_valid), .b_ready(f_b_ready), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
    .b_rvalid(f_b_rvalid), .b_rready(b_rready), .b_result(f_b_result), .b_zero(f_b_zero),
    .busy(f_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = y % 32;
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLL:  return x << sh;
      OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
      OP_XOR:  return x ^ y;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $unsigned($signed(x) >>> sh);
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      default: return 32'd0;
    endcase
  endfunction

  // Winner of an idle-cycle arbitration (0 = A, 1 = B).
  function automatic logic pick(input logic av, input logic bv, input logic last);
    if (av && bv) return !last;
    return bv;
  endfunction

  logic        m_busy = 0, m_owner = 0, m_last = 1, m_zero = 0;
  logic [31:0] m_result = 0;
  logic        grant_log[$];

  // Model advance: one transaction outstanding, released by the owner's rready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_result = 0; m_zero = 0;
    end else if (!m_busy) begin
      if (a_valid || b_valid) begin
        m_owner  = pick(a_valid, b_valid, m_last);
        m_result = m_owner ? ref_alu(b_op, b_in1, b_in2) : ref_alu(a_op, a_in1, a_in2);
        m_zero   = (m_result == 0);
        m_last   = m_owner;
        m_busy   = 1;
        grant_log.push_back(m_owner);
      end
    end else if (m_owner ? b_rready : a_rready) begin
      m_busy = 0;
    end
  end

  // Every-cycle comparison of the round-robin instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      logic g;
      check("busy", busy, m_busy);
      check("a_rvalid", a_rvalid, m_busy && !m_owner);
      check("b_rvalid", b_rvalid, m_busy && m_owner);
      check("a_result", a_result, (m_busy && !m_owner) ? m_result : 32'd0);
      check("a_zero", a_zero, m_busy && !m_owner && m_zero);
      check("b_result", b_result, (m_busy && m_owner) ? m_result : 32'd0);
      check("b_zero", b_zero, m_busy && m_owner && m_zero);
      if (m_busy) begin
        check("a_ready_resp", a_ready, 0);
        check("b_ready_resp", b_ready, 0);
      end else if (a_valid || b_valid) begin
        g = pick(a_valid, b_valid, m_last);
        check("a_ready_idle", a_ready, !g);
        check("b_ready_idle", b_ready, g);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input logic v, input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
    a_valid = v; a_op = op; a_in1 = x; a_in2 = y;
  endtask

  task automatic drive_b(input logic v, input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
    b_valid = v; b_op = op; b_in1 = x; b_in2 = y;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  // A-only transaction with a bounded wait for a_ready and a literal result check.
  task automatic run_a(input string name, input alu_op_t op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_r, input logic exp_z);
    bit got = 0;
    drive_a(1, op, x, y); a_rready = 1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (a_ready) got = 1;
      step();
    end
    check({name, "_accept"}, got, 1);
    a_valid = 0;
    @(negedge clk);
    check({name, "_result"}, a_result, exp_r);
    check({name, "_zero"}, a_zero, exp_z);
    step(); a_rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f_acc, f_bseen;

    // Reset state: readies, rvalids and busy low while rst is high.
    a_valid = 1; #2;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_busy", busy, 0);
    a_valid = 0;
    step(); step(); rst = 0;

    // 1: A only, ADD 5,7.
    drive_a(1, OP_ADD, 5, 7);
    @(negedge clk); check("t1_a_ready", a_ready, 1);
    step(); a_valid = 0;
    @(negedge clk);
    check("t1_a_rvalid", a_rvalid, 1); check("t1_a_result", a_result, 12);
    check("t1_a_zero", a_zero, 0); check("t1_b_rvalid", b_rvalid, 0); check("t1_busy", busy, 1);
    step();
    @(negedge clk); check("t1_busy_hold", busy, 1); check("t1_result_hold", a_result, 12);
    a_rready = 1; step(); a_rready = 0;
    @(negedge clk); check("t1_busy_done", busy, 0);

    // 2: first tie after reset goes to A, then B.
    do_reset();
    drive_a(1, OP_SUB, 9, 9); drive_b(1, OP_XOR, 32'hF0, 32'h0F);
    a_rready = 1; b_rready = 1;
    @(negedge clk); check("t2_a_ready", a_ready, 1); check("t2_b_ready", b_ready, 0);
    step(); a_valid = 0;
    @(negedge clk);
    check("t2_a_result", a_result, 0); check("t2_a_zero", a_zero, 1); check("t2_b_ready_resp", b_ready, 0);
    step();
    @(negedge clk); check("t2_b_ready_idle", b_ready, 1);
    step(); b_valid = 0;
    @(negedge clk); check("t2_b_rvalid", b_rvalid, 1); check("t2_b_result", b_result, 32'hFF);
    step();

    // 3: both continuously valid; round-robin alternates, fixed priority always A.
    do_reset();
    drive_a(1, OP_ADD, 1, 2); drive_b(1, OP_ADD, 3, 4);
    a_rready = 1; b_rready = 1;
    n0 = grant_log.size(); f_acc = 0; f_bseen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (f_a_ready) f_acc++;
      if (f_b_ready) f_bseen++;
      step();
    end
    check("t3_rr_count", grant_log.size() - n0, 4);
    if (grant_log.size() - n0 >= 4) begin
      check("t3_rr_g0", grant_log[n0],     0);
      check("t3_rr_g1", grant_log[n0 + 1], 1);
      check("t3_rr_g2", grant_log[n0 + 2], 0);
      check("t3_rr_g3", grant_log[n0 + 3], 1);
    end
    check("t3_fix_a_accepts", f_acc, 4);
    check("t3_fix_b_ready", f_bseen, 0);
    a_valid = 0; b_valid = 0; a_rready = 0; b_rready = 0;

    // 4: backpressure on B while A waits.
    drive_b(1, OP_SLL, 1, 31);
    @(negedge clk); check("t4_b_ready", b_ready, 1);
    step(); b_valid = 0; drive_a(1, OP_ADD, 2, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_b_rvalid", b_rvalid, 1); check("t4_b_result", b_result, 32'h8000_0000);
      check("t4_a_ready", a_ready, 0);
      step();
    end
    b_rready = 1; step(); b_rready = 0;
    @(negedge clk); check("t4_a_ready_after", a_ready, 1);
    step(); a_valid = 0; a_rready = 1;
    @(negedge clk); check("t4_a_result", a_result, 5);
    step(); a_rready = 0;

    // 5: opcode sweep on A.
    run_a("t5_sra",  OP_SRA,  32'h8000_0000, 4,  32'hF800_0000, 0);
    run_a("t5_slt",  OP_SLT,  32'hFFFF_FFFF, 1,  32'd1, 0);
    run_a("t5_sltu", OP_SLTU, 32'hFFFF_FFFF, 1,  32'd0, 1);
    run_a("t5_srl",  OP_SRL,  32'h8000_0000, 36, 32'h0800_0000, 0);
    run_a("t5_undef", 4'b1111, 32'h1234, 32'h5678, 32'd0, 1);

    // 6: reset mid-response, then the first tie again goes to A.
    drive_a(1, OP_ADD, 3, 4);
    step(); a_valid = 0;
    @(negedge clk); check("t6_a_rvalid_pre", a_rvalid, 1);
    #2 rst = 1; a_valid = 1;
    #1;
    check("t6_a_rvalid_async", a_rvalid, 0);
    check("t6_busy_async", busy, 0);
    check("t6_a_ready_rst", a_ready, 0);
    step(); rst = 0;
    drive_a(1, OP_ADD, 1, 1); drive_b(1, OP_ADD, 2, 2);
    a_rready = 1; b_rready = 1;
    @(negedge clk); check("t6_a_ready", a_ready, 1); check("t6_b_ready", b_ready, 0);
    step(); a_valid = 0;
    @(negedge clk); check("t6_a_rvalid", a_rvalid, 1); check("t6_a_result", a_result, 2);
    step(); step(); b_valid = 0;
    @(negedge clk); check("t6_b_result", b_result, 4);
    step(); a_rready = 0; b_rready = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Shares one instance of the existing RV32E ALU between two requesters, port A (EXU) and port B (branch/AGU helper). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates (round-robin or fixed priority) and registers the ALU result and zero flag. It keeps one transaction in flight and holds that result until the owning requester accepts it.

Parameters:
PRIO_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority, A always wins ties.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
a_valid  in  1  A request valid
a_ready  out  1  A request accepted this cycle when a_valid & a_ready
a_op  in  4  A ALU opcode (shared ALU op encoding)
a_in1  in  32  A operand 1
a_in2  in  32  A operand 2
a_rvalid  out  1  A response valid
a_rready  in  1  A response consumed
a_result  out  32  A result
a_zero  out  1  A zero flag
b_valid, b_ready, b_op, b_in1, b_in2, b_rvalid, b_rready, b_result, b_zero: same as the A ports, for port B
busy  out  1  high while in state RESP

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; owner=0; last_grant=B (so A wins the first tie); result_q=0; zero_q=0. All rvalid outputs are 0, busy=0, and all ready outputs are 0 while rst is high.
- FSM has two states:
  - IDLE: grant is computed combinationally.
    - Only one requester valid: that requester is granted.
    - Both valid, PRIO_MODE=0: grant goes to the port that is not last_grant.
    - Both valid, PRIO_MODE=1: grant goes to A.
    - x_ready = (state==IDLE) & grant==x. The non-granted ready is 0.
    - ALU inputs (op, in1, in2) are muxed from the granted port.
  - Accept: accept = x_valid & x_ready. On the accept edge:
    - result_q <= alu.out; zero_q <= alu.zero; owner <= x; last_grant <= x; state <= RESP.
  - RESP:
    - x_rvalid = (owner==x). The other port's rvalid is 0.
    - x_result and x_zero drive result_q/zero_q while rvalid is high. They drive 0 otherwise.
    - All ready outputs are 0.
    - On owner rvalid & rready: state <= IDLE.
- Latency and throughput:
  - Response is valid 1 cycle after the accept edge.
  - Minimum 2 cycles per transaction; no accept in the cycle of the response handshake.
- Combinational paths:
  - a_ready depends combinationally on b_valid, and b_ready on a_valid.
  - Requesters must not derive valid from ready.
  - Request payload must be held stable only until accepted; operands are captured at accept.
- Backpressure: in RESP, result_q, zero_q, owner and rvalid hold indefinitely until rready. A pending request on the other port waits with ready=0.
- rready asserted with no rvalid for that port is ignored.
- Arithmetic is exactly the ALU's:
  - 32-bit wrapping add and sub.
  - Shift amount is in2[4:0].
  - SLT is signed; SLTU is unsigned.
  - Undefined opcodes give 0 with zero=1.
- Reset mid-operation: any in-flight result is discarded. rvalid drops asynchronously and the FSM returns to IDLE. The requester must reissue.
- Starvation: PRIO_MODE=0 guarantees that a continuously valid port is granted within 2 transactions. PRIO_MODE=1 gives B no such guarantee (documented).

Decomposition:
- Shared package holds:
  - ALU opcode constants (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9) and a 4-bit alu_op type.
  - Requester id constants REQ_A=0, REQ_B=1.
  - FSM state encoding IDLE/RESP.
- Sub-module: exactly one instance of the existing alu module. Arbitration, muxing, FSM and result registers stay in alu_share_arb.

Test Plan:
1. A only: ADD 5,7 -> a_ready=1 in cycle 0; a_rvalid=1 in cycle 1, a_result=12, a_zero=0; b_rvalid stays 0; busy=1 until a_rready.
2. Both valid first after reset: A SUB 9,9 and B XOR 0xF0,0x0F.
   - A is granted first: a_result=0, a_zero=1, b_ready=0 throughout.
   - After the A response handshake, B is accepted: b_result=0xFF.
3. Both continuously valid with rready=1, PRIO_MODE=0 -> grants alternate A,B,A,B, one accept every 2 cycles. With PRIO_MODE=1 -> A is granted every time and b_ready stays 0.
4. Backpressure: B SLL 1,31, b_rready held low 4 cycles.
   - b_rvalid=1 and b_result=0x80000000 stay stable throughout.
   - A is pending with a_ready=0.
   - After b_rready the FSM returns to IDLE, then A is accepted.
5. Opcode sweep on A:
   - SRA 0x80000000,4 -> 0xF8000000.
   - SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
   - SRL 0x80000000,36 -> 0x08000000 (shift amount masked to 4).
   - Op 4'b1111 -> 0 with zero=1.
6. Assert rst in RESP mid-cycle -> a_rvalid and busy fall immediately (async). After deassert, a new A ADD 1,1 -> result 2 in 1 cycle, and the first tie again goes to A.
